// File: rtl/unpacked_array_pkg.sv
// unpacked_array_pkg: shared types and width helpers for the unpacked-array serializer.
package unpacked_array_pkg;
  typedef enum logic {S_IDLE, S_SHIFT} ser_state_e;
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/word_fifo.sv
// word_fifo: word FIFO stored element-wise in a size-declared unpacked array.
module word_fifo
  import unpacked_array_pkg::*;
#(
  parameter int M     = 2,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         wr_data [M],
  output logic                         rd_data [M],
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = min1_clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic          mem [DEPTH][M];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  assign full    = count_q == CW'(DEPTH);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  // Pointers wrap by explicit compare so DEPTH need not be a power of two
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && count_q != '0;
    wr_ptr_d = do_push ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = do_pop ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/unpacked_array_serializer.sv
// unpacked_array_serializer: buffers packed words and streams them out one element per beat,
// element 0 first, through an unpacked-array shift register.
module unpacked_array_serializer
  import unpacked_array_pkg::*;
#(
  parameter int M     = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic [M-1:0]               d,
  input  logic                       d_valid,
  output logic                       d_ready,
  output logic                       q,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic                       q_last,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int IW = min1_clog2(M);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST = IW'(M - 1);
  ser_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sh_q [M];
  logic          sh_d [M];
  logic          wr_data [M];
  logic          rd_data [M];
  logic          q_q, q_d, valid_q, valid_d, last_q, last_d;
  logic          pop, adv, done, full;
  logic [CW-1:0] count;
  word_fifo #(.M(M), .DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .rst_n  (rst_n),
    .push   (d_valid),
    .pop    (pop),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .full   (full),
    .count  (count)
  );
  assign d_ready = !full;
  assign level   = count;
  assign q       = q_q;
  assign q_valid = valid_q;
  assign q_last  = last_q;
  always_comb begin
    for (int i = 0; i < M; i++) wr_data[i] = d[i];
  end
  // count is sampled before any same-edge push, so a word pushed alongside the last beat waits a cycle
  always_comb begin
    pop     = count != '0 && (state_q == S_IDLE || (q_ready && idx_q == LAST));
    adv     = state_q == S_SHIFT && q_ready && idx_q != LAST;
    done    = state_q == S_SHIFT && q_ready && idx_q == LAST && !pop;
    state_d = pop ? S_SHIFT : done ? S_IDLE : state_q;
    idx_d   = pop ? '0 : adv ? idx_q + 1'b1 : idx_q;
    q_d     = pop ? rd_data[0] : adv ? sh_q[idx_q + 1'b1] : q_q;
    valid_d = pop || (valid_q && !done);
    last_d  = pop ? (M == 1) : adv ? (idx_q + 1'b1 == LAST) : done ? 1'b0 : last_q;
    sh_d    = sh_q;
    if (pop) sh_d = rd_data;
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sh_q    <= '{default: 1'b0};
      q_q     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
endmodule
